// File: rtl/ldl_round_dispatch.sv
// Round-robin scatter: one valid/ready source stream is dealt across
// REQ_WIDTH sink lanes, one beat per lane in rotating order, through a single
// registered output stage (1-cycle latency, one beat per cycle when the
// target lanes are ready). Lanes join or leave the rotation through lane_en.
//
// Handshake: a beat moves on a rising clk edge when valid & ready are both
// high on that interface. The source side uses s_valid/s_ready. Each sink lane
// i uses m_valid[i]/m_ready[i]. At most one m_valid bit is high, and it is
// always the bit selected by m_bin. While a beat is offered, m_valid, m_data
// and m_bin stay stable until the target lane accepts the beat. s_ready does
// not depend on s_valid.
module ldl_round_dispatch #(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [REQ_WIDTH-1:0]  lane_en,
  output logic [REQ_WIDTH-1:0]  m_valid,
  input  logic [REQ_WIDTH-1:0]  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [BIN_WIDTH-1:0]  m_bin
);

  logic                 busy;
  logic                 done;
  logic                 accept;
  logic [BIN_WIDTH-1:0] next_bin;
  logic [BIN_WIDTH-1:0] low_any;
  logic [BIN_WIDTH-1:0] low_above;
  logic                 any_above;

  // Pick the next lane. Scanning from the top down leaves the lowest enabled
  // index in low_any and the lowest enabled index above m_bin in low_above.
  // When no enabled lane lies above m_bin, the rotation wraps to low_any.
  always_comb begin
    low_any   = '0;
    low_above = '0;
    any_above = 1'b0;
    for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
      if (lane_en[i]) begin
        low_any = BIN_WIDTH'(i);
        if (BIN_WIDTH'(i) > m_bin) begin
          low_above = BIN_WIDTH'(i);
          any_above = 1'b1;
        end
      end
    end
    next_bin = any_above ? low_above : low_any;
  end

  // Ready bits of idle lanes are ignored. A beat finishing on this edge frees
  // the stage for a new beat on the same edge.
  always_comb begin
    busy    = |m_valid;
    done    = busy & m_ready[m_bin];
    s_ready = (|lane_en) & (~busy | done);
    accept  = s_valid & s_ready;
  end

  // Output stage. An accepted beat replaces the previous one. A finished beat
  // with nothing to replace it clears valid and leaves data and bin in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= '0;
      m_data  <= '0;
      m_bin   <= '1;
    end else if (accept) begin
      m_data  <= s_data;
      m_bin   <= next_bin;
      m_valid <= {{(REQ_WIDTH-1){1'b0}}, 1'b1} << next_bin;
    end else if (done) begin
      m_valid <= '0;
    end
  end

endmodule

// File: tb/tb_ldl_round_dispatch.sv
// Testbench for ldl_round_dispatch: a cycle-by-cycle vector table with
// hand-computed outputs, a back-to-back rotation sequence, and a payload
// scoreboard that follows beats from source acceptance to lane delivery.
module tb_ldl_round_dispatch;

  localparam int BW = 3;
  localparam int RW = 1 << BW;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [RW-1:0] lane_en;
  logic [RW-1:0] m_valid;
  logic [RW-1:0] m_ready;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_bin;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          rst_n;
    logic          sv;
    logic [DW-1:0] sd;
    logic [RW-1:0] en;
    logic [RW-1:0] rdy;
    logic          e_sr;
    logic [RW-1:0] e_mv;
    logic [DW-1:0] e_md;
    logic [BW-1:0] e_mb;
  } vec_t;

  vec_t vecs[$];

  ldl_round_dispatch #(.BIN_WIDTH(BW), .REQ_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .lane_en (lane_en),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_bin   (m_bin)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic sv, input logic [DW-1:0] sd,
                         input logic [RW-1:0] en, input logic [RW-1:0] rdy,
                         input logic e_sr, input logic [RW-1:0] e_mv,
                         input logic [DW-1:0] e_md, input logic [BW-1:0] e_mb);
    vec_t v;
    v.rst_n = r; v.sv = sv; v.sd = sd; v.en = en; v.rdy = rdy;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_mb = e_mb;
    vecs.push_back(v);
  endtask

  // Scoreboard: a beat delivered to its lane must carry the oldest accepted
  // payload. Reset drops whatever is still pending.
  task automatic scoreboard_edge();
    logic [DW-1:0] exp_d;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if ((|m_valid) && m_ready[m_bin]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: delivered %0h with no beat accepted", m_data);
        end else begin
          exp_d = exp_q.pop_front();
          check("sb_data", 32'(m_data), 32'(exp_d));
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  endtask

  // Drive one cycle: inputs at negedge, s_ready checked before the edge,
  // registered outputs checked 1 time unit after it.
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    rst_n   = v.rst_n;
    s_valid = v.sv;
    s_data  = v.sd;
    lane_en = v.en;
    m_ready = v.rdy;
    #1;
    check($sformatf("s_ready[%0d]", idx), 32'(s_ready), 32'(v.e_sr));
    scoreboard_edge();
    @(posedge clk);
    #1;
    check($sformatf("m_valid[%0d]", idx), 32'(m_valid), 32'(v.e_mv));
    check($sformatf("m_data[%0d]", idx), 32'(m_data), 32'(v.e_md));
    check($sformatf("m_bin[%0d]", idx), 32'(m_bin), 32'(v.e_mb));
  endtask

  initial begin
    vec_t v;
    logic [BW-1:0] b;

    // Reset
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; lane_en = 8'hFF; m_ready = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_valid", 32'(m_valid), 32'h0);
    check("reset_m_data", 32'(m_data), 32'h0);
    check("reset_m_bin", 32'(m_bin), 32'h7);

    //       rst sv  sd     en     rdy    sr  mv     md     bin
    // 1: back-to-back beats, all lanes
    add_vec(1, 1, 8'hA1, 8'hFF, 8'hFF, 1, 8'h01, 8'hA1, 3'd0);
    add_vec(1, 1, 8'hB2, 8'hFF, 8'hFF, 1, 8'h02, 8'hB2, 3'd1);
    add_vec(1, 1, 8'hC3, 8'hFF, 8'hFF, 1, 8'h04, 8'hC3, 3'd2);
    add_vec(1, 0, 8'h00, 8'hFF, 8'hFF, 1, 8'h00, 8'hC3, 3'd2);
    // 2: sparse lanes 2,5,7 from reset, wrap to 2
    add_vec(0, 0, 8'h00, 8'hA4, 8'hFF, 1, 8'h00, 8'h00, 3'd7);
    add_vec(1, 1, 8'h11, 8'hA4, 8'hFF, 1, 8'h04, 8'h11, 3'd2);
    add_vec(1, 1, 8'h22, 8'hA4, 8'hFF, 1, 8'h20, 8'h22, 3'd5);
    add_vec(1, 1, 8'h33, 8'hA4, 8'hFF, 1, 8'h80, 8'h33, 3'd7);
    add_vec(1, 1, 8'h44, 8'hA4, 8'hFF, 1, 8'h04, 8'h44, 3'd2);
    add_vec(1, 0, 8'h00, 8'hA4, 8'hFF, 1, 8'h00, 8'h44, 3'd2);
    // 3: stall on lane 1 (other lanes' ready ignored), then no-gap handoff
    add_vec(1, 1, 8'h55, 8'h02, 8'hFF, 1, 8'h02, 8'h55, 3'd1);
    add_vec(1, 1, 8'h66, 8'hFF, 8'hFD, 0, 8'h02, 8'h55, 3'd1);
    add_vec(1, 1, 8'h66, 8'hFF, 8'hFD, 0, 8'h02, 8'h55, 3'd1);
    add_vec(1, 1, 8'h66, 8'hFF, 8'hFD, 0, 8'h02, 8'h55, 3'd1);
    add_vec(1, 1, 8'h66, 8'hFF, 8'h02, 1, 8'h04, 8'h66, 3'd2);
    // 4: all lanes disabled with a beat pending; it still drains on lane 2
    add_vec(1, 1, 8'h77, 8'h00, 8'h00, 0, 8'h04, 8'h66, 3'd2);
    add_vec(1, 1, 8'h77, 8'h00, 8'h00, 0, 8'h04, 8'h66, 3'd2);
    add_vec(1, 1, 8'h77, 8'h00, 8'h04, 0, 8'h00, 8'h66, 3'd2);
    add_vec(1, 1, 8'h77, 8'h00, 8'hFF, 0, 8'h00, 8'h66, 3'd2);
    // 5: single enabled lane 0
    add_vec(1, 1, 8'h81, 8'h01, 8'hFF, 1, 8'h01, 8'h81, 3'd0);
    add_vec(1, 1, 8'h82, 8'h01, 8'hFF, 1, 8'h01, 8'h82, 3'd0);
    add_vec(1, 1, 8'h83, 8'h01, 8'hFF, 1, 8'h01, 8'h83, 3'd0);
    add_vec(1, 1, 8'h84, 8'h01, 8'hFF, 1, 8'h01, 8'h84, 3'd0);
    add_vec(1, 1, 8'h85, 8'h01, 8'hFF, 1, 8'h01, 8'h85, 3'd0);
    // 6: reset with a beat pending on lane 3, then restart on lanes 4,5
    add_vec(1, 1, 8'h90, 8'h08, 8'hFF, 1, 8'h08, 8'h90, 3'd3);
    add_vec(1, 0, 8'h00, 8'h08, 8'h00, 0, 8'h08, 8'h90, 3'd3);
    add_vec(0, 1, 8'h91, 8'h30, 8'h00, 0, 8'h00, 8'h00, 3'd7);
    add_vec(1, 1, 8'h92, 8'h30, 8'h00, 1, 8'h10, 8'h92, 3'd4);
    add_vec(1, 1, 8'h93, 8'h30, 8'h00, 0, 8'h10, 8'h92, 3'd4);
    add_vec(1, 1, 8'h93, 8'h30, 8'h10, 1, 8'h20, 8'h93, 3'd5);
    add_vec(1, 0, 8'h00, 8'h30, 8'hFF, 1, 8'h00, 8'h93, 3'd5);

    foreach (vecs[i]) step(vecs[i], i);

    // Full-throughput rotation: 16 back-to-back beats starting after lane 5
    for (int i = 0; i < 16; i++) begin
      b = BW'((6 + i) % RW);
      v.rst_n = 1'b1; v.sv = 1'b1; v.sd = DW'(8'hC0 + i); v.en = 8'hFF; v.rdy = 8'hFF;
      v.e_sr = 1'b1; v.e_mv = 8'h01 << b; v.e_md = DW'(8'hC0 + i); v.e_mb = b;
      step(v, 100 + i);
    end
    v.rst_n = 1'b1; v.sv = 1'b0; v.sd = '0; v.en = 8'hFF; v.rdy = 8'hFF;
    v.e_sr = 1'b1; v.e_mv = 8'h00; v.e_md = 8'hCF; v.e_mb = 3'd5;
    step(v, 116);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
